// File: rtl/wr_reg_dest_sb.sv
// Register-file write-destination selector with a one-entry valid/ready
// output stage and a per-register pending-write scoreboard. The control
// unit uses the scoreboard to stall on RAW hazards until write-back retires.
module wr_reg_dest_sb #(
  parameter int ADDR_W = 5,
  parameter int RT_LSB = 16,
  parameter int RD_LSB = 11,
  parameter int SP_IDX = 29,
  parameter int RA_IDX = 31,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        selector,
  input  logic [31:0]       instr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              retire_valid,
  input  logic [ADDR_W-1:0] retire_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              err_underflow
);

  localparam int                NREG    = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  // Fixed indices are zero-extended or truncated to the index width.
  localparam logic [ADDR_W-1:0] SP_A    = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] RA_A    = ADDR_W'(RA_IDX);

  typedef enum logic [1:0] {
    SEL_RT = 2'b00,
    SEL_SP = 2'b01,
    SEL_RA = 2'b10,
    SEL_RD = 2'b11
  } sel_e;

  logic [ADDR_W-1:0] sel_addr;
  logic              accept;
  logic              retire_hit;
  logic              underflow_ev;
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic              err_q,       err_d;
  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];

  // Only the rt/rd fields of the instruction matter here; the rest of the
  // word is deliberately ignored.
  logic unused_instr;
  assign unused_instr = ^instr;

  // Destination index mux driven by the selector.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    sel_addr = '0;
    unique case (sel_e'(selector))
      SEL_RT: sel_addr = instr[RT_LSB +: ADDR_W];
      SEL_SP: sel_addr = SP_A;
      SEL_RA: sel_addr = RA_A;
      SEL_RD: sel_addr = instr[RD_LSB +: ADDR_W];
      default: sel_addr = '0;
    endcase
  end

  // Accept when the output slot frees up this cycle and the target counter
  // has headroom; a same-cycle retire does not count as headroom.
  assign in_ready = (!out_valid_q || out_ready) &&
                    ((sel_addr == '0) || (cnt_q[sel_addr] != CNT_MAX));
  assign accept   = in_valid && in_ready;

  // Retires act on the pre-edge count; register 0 is never tracked.
  assign retire_hit   = retire_valid && (retire_addr != '0);
  assign underflow_ev = retire_hit && (cnt_q[retire_addr] == '0);

  // One-hot increment/decrement requests per register.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (accept && (sel_addr != '0)) inc_vec[sel_addr] = 1'b1;
    if (retire_hit && !underflow_ev) dec_vec[retire_addr] = 1'b1;
  end

  // Counter next state; simultaneous inc and dec on one index cancel.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NREG; i++) begin
      if (inc_vec[i] && !dec_vec[i])      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (dec_vec[i] && !inc_vec[i]) cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
  end

  // Output stage next state: load on accept, drain on consumer take, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_addr_d  = sel_addr;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    err_d = err_q | underflow_ev;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      err_q       <= 1'b0;
      // NOTE: this counter array is cleared on reset, unlike a plain storage
      // RAM, because stale pending counts would stall the pipeline forever.
      cnt_q       <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_addr      = out_addr_q;
  assign err_underflow = err_q;
  assign rs_busy       = (rs_addr != '0) && (cnt_q[rs_addr] != '0);
  assign rt_busy       = (rt_addr != '0) && (cnt_q[rt_addr] != '0);

endmodule
